// File: rtl/sign_magnitude_split.sv
// 2's-complement to sign/magnitude converter with a registered valid/ready
// handshake and a 2-entry skid buffer. Define SIGN_MAGNITUDE_SPLIT_CLAMP_EN to clamp -2^(W-1) to 2^(W-1)-1.
module sign_magnitude_split #(
    parameter int DATA_WIDTH = 12,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] mag_o,
    output logic                  sign_o,
    output logic                  zero_o,
    output logic                  sat_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [CNT_WIDTH-1:0]  minneg_cnt_o
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] mag;
        logic                  sign;
        logic                  zero;
        logic                  sat;
    } word_t;

    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    word_t                 conv;
    word_t                 out_q;
    word_t                 skid_q;
    logic                  out_vld;
    logic                  skid_vld;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [DATA_WIDTH-1:0] neg_val;
    logic                  in_xfer;
    logic                  out_xfer;

    assign neg_val = ~data_i + 1'b1;

    always_comb begin
        conv      = '0;
        conv.sign = data_i[DATA_WIDTH-1];
        conv.zero = (data_i == '0);
        conv.sat  = (data_i == MIN_NEG);
`ifdef SIGN_MAGNITUDE_SPLIT_CLAMP_EN
        conv.mag  = conv.sat ? MAX_POS : (conv.sign ? neg_val : data_i);
`else
        conv.mag  = conv.sign ? neg_val : data_i;
`endif
    end

    // ready_o depends only on the skid flag, so ready_i never reaches it combinationally.
    assign ready_o  = !skid_vld;
    assign in_xfer  = valid_i && !skid_vld;
    assign out_xfer = out_vld && ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q    <= '0;
            skid_q   <= '0;
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (out_xfer && skid_vld) begin
                out_q    <= skid_q;
                skid_vld <= 1'b0;
            end else if (in_xfer && (!out_vld || out_xfer)) begin
                out_q   <= conv;
                out_vld <= 1'b1;
            end else if (in_xfer) begin
                skid_q   <= conv;
                skid_vld <= 1'b1;
            end else if (out_xfer) begin
                out_vld <= 1'b0;
            end

            if (in_xfer && conv.sat && (cnt_q != {CNT_WIDTH{1'b1}}))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign mag_o        = out_q.mag;
    assign sign_o       = out_q.sign;
    assign zero_o       = out_q.zero;
    assign sat_o        = out_q.sat;
    assign valid_o      = out_vld;
    assign minneg_cnt_o = cnt_q;

endmodule

// File: tb/tb_sign_magnitude_split.sv
// Self-checking bench for sign_magnitude_split: random streams scored against
// an integer-arithmetic reference model, plus directed corner cases.
module tb_sign_magnitude_split;

    localparam int DW = 12;
    localparam int CW = 2;
    localparam int CNT_MAX = 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [DW-1:0] data_i;
    logic          valid_i;
    logic          ready_o;
    logic [DW-1:0] mag_o;
    logic          sign_o;
    logic          zero_o;
    logic          sat_o;
    logic          valid_o;
    logic          ready_i;
    logic [CW-1:0] minneg_cnt_o;

    sign_magnitude_split #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o), .mag_o(mag_o), .sign_o(sign_o), .zero_o(zero_o),
        .sat_o(sat_o), .valid_o(valid_o), .ready_i(ready_i),
        .minneg_cnt_o(minneg_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int cnt_model = 0;

    logic [DW+2:0] exp_q[$];
    logic [DW+2:0] obs_q[$];
    int            in_cyc_q[$];
    int            obs_cyc_q[$];

    logic [DW+2:0] cur_out;
    logic          cur_vld;
    logic          cur_stall;
    logic          cur_rdy;
    logic          in_fire;

    // Reference: signed value as an integer, magnitude as its absolute value.
    function automatic logic [DW+2:0] model(input logic [DW-1:0] d);
        int v;
        int m;
        logic [31:0] mm;
        v = d[DW-1] ? int'(d) - (1 << DW) : int'(d);
        m = (v < 0) ? -v : v;
`ifdef SIGN_MAGNITUDE_SPLIT_CLAMP_EN
        if (m == (1 << (DW-1))) m = (1 << (DW-1)) - 1;
`endif
        mm = m;
        return {mm[DW-1:0], v < 0, v == 0, v == -(1 << (DW-1))};
    endfunction

    // Advance one clock, recording both handshakes as seen at the negedge.
    task automatic tick();
        logic [DW+2:0] w;
        @(negedge clk_i);
        cur_out   = {mag_o, sign_o, zero_o, sat_o};
        cur_vld   = valid_o;
        cur_rdy   = ready_o;
        cur_stall = valid_o && !ready_i;
        in_fire   = valid_i && ready_o && !rst_i;
        if (in_fire) begin
            w = model(data_i);
            exp_q.push_back(w);
            in_cyc_q.push_back(cyc);
            if (w[0]) cnt_model++;
        end
        if (valid_o && ready_i && !rst_i) begin
            obs_q.push_back(cur_out);
            obs_cyc_q.push_back(cyc);
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
        tick();
        rst_i = 1'b0;
        exp_q.delete(); obs_q.delete(); in_cyc_q.delete(); obs_cyc_q.delete();
        cnt_model = 0;
    endtask

    task automatic test_reset();
        valid_i = 1'b1; ready_i = 1'b0; data_i = 12'h800;
        tick(); tick(); tick();
        do_reset();
        n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_o); end
        n_cmp++; if ({mag_o, sign_o, zero_o, sat_o} !== '0) begin n_fail++; $display("FAIL reset_word got %h want 0", {mag_o, sign_o, zero_o, sat_o}); end
        n_cmp++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready_o); end
        n_cmp++; if (minneg_cnt_o !== '0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", minneg_cnt_o); end
    endtask

    task automatic test_convert();
        logic [DW-1:0] din [4] = '{12'hFFB, 12'h7FF, 12'h000, 12'h801};
        logic [DW+2:0] want[4] = '{{12'd5, 3'b100}, {12'd2047, 3'b000}, {12'd0, 3'b010}, {12'd2047, 3'b100}};
        do_reset();
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1; data_i = din[i];
            tick();
            valid_i = 1'b0; data_i = 'x;
            n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL conv_valid[%0d] got %b want 1", i, valid_o); end
            n_cmp++; if ({mag_o, sign_o, zero_o, sat_o} !== want[i]) begin n_fail++; $display("FAIL conv_word[%0d] got %h want %h", i, {mag_o, sign_o, zero_o, sat_o}, want[i]); end
        end
        tick();
        n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL conv_drain got valid %b want 0", valid_o); end
    endtask

    task automatic test_minneg();
        logic [DW-1:0] want_mag;
`ifdef SIGN_MAGNITUDE_SPLIT_CLAMP_EN
        want_mag = 12'h7FF;
`else
        want_mag = 12'h800;
`endif
        do_reset();
        ready_i = 1'b1; valid_i = 1'b1; data_i = 12'h800;
        tick();
        valid_i = 1'b0;
        n_cmp++; if ({valid_o, sign_o, zero_o, sat_o} !== 4'b1101) begin n_fail++; $display("FAIL minneg_flags got %b want 1101", {valid_o, sign_o, zero_o, sat_o}); end
        n_cmp++; if (mag_o !== want_mag) begin n_fail++; $display("FAIL minneg_mag got %h want %h", mag_o, want_mag); end
        n_cmp++; if (minneg_cnt_o !== 2'd1) begin n_fail++; $display("FAIL minneg_cnt got %0d want 1", minneg_cnt_o); end
    endtask

    task automatic test_backpressure();
        int  sent = 0;
        bit  saw_low = 0;
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            valid_i = (sent < 5);
            data_i  = DW'(sent + 1);
            ready_i = !(c >= 2 && c <= 4);
            tick();
            if (in_fire) sent++;
            if (c == 3 && !cur_rdy) saw_low = 1;
        end
        valid_i = 1'b0;
        n_cmp++; if (saw_low !== 1'b1) begin n_fail++; $display("FAIL bp_ready_low got %b want 1", saw_low); end
        n_cmp++; if (obs_q.size() !== 5) begin n_fail++; $display("FAIL bp_count got %0d want 5", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < 5; i++) begin
            n_cmp++; if (obs_q[i][DW+2:3] !== DW'(i + 1)) begin n_fail++; $display("FAIL bp_seq[%0d] got %0d want %0d", i, obs_q[i][DW+2:3], i + 1); end
            if (i > 0) begin
                n_cmp++; if (obs_cyc_q[i] !== obs_cyc_q[i-1] + 1) begin n_fail++; $display("FAIL bp_gap[%0d] got cycle %0d want %0d", i, obs_cyc_q[i], obs_cyc_q[i-1] + 1); end
            end
        end
    endtask

    task automatic test_full_rate();
        do_reset();
        ready_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            valid_i = 1'b1;
            data_i  = ($urandom_range(0, 9) == 0) ? 12'h800 : DW'($urandom);
            tick();
            n_cmp++; if (in_fire !== 1'b1) begin n_fail++; $display("FAIL fr_accept[%0d] got %b want 1", i, in_fire); end
        end
        valid_i = 1'b0;
        tick(); tick();
        n_cmp++; if (obs_q.size() !== 100 || exp_q.size() !== 100) begin n_fail++; $display("FAIL fr_count got %0d want 100", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL fr_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
            n_cmp++; if (obs_cyc_q[i] !== in_cyc_q[i] + 1) begin n_fail++; $display("FAIL fr_latency[%0d] got %0d want %0d", i, obs_cyc_q[i] - in_cyc_q[i], 1); end
        end
        n_cmp++; if (int'(minneg_cnt_o) !== (cnt_model > CNT_MAX ? CNT_MAX : cnt_model)) begin n_fail++; $display("FAIL fr_cnt got %0d want %0d", minneg_cnt_o, cnt_model > CNT_MAX ? CNT_MAX : cnt_model); end
    endtask

    task automatic test_random_backpressure();
        logic [DW+2:0] p_out;
        logic          p_stall;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            data_i  = valid_i ? DW'($urandom) : 'x;
            ready_i = ($urandom_range(0, 2) != 0);
            p_stall = cur_stall;
            p_out   = cur_out;
            tick();
            if (p_stall && i > 0) begin
                n_cmp++; if (!cur_vld || cur_out !== p_out) begin n_fail++; $display("FAIL rb_hold[%0d] got %h/%b want %h/1", i, cur_out, cur_vld, p_out); end
            end
        end
        valid_i = 1'b0; ready_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rb_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rb_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_counter_sat();
        do_reset();
        ready_i = 1'b1; data_i = 12'h800;
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1;
            tick();
            n_cmp++; if (int'(minneg_cnt_o) !== (cnt_model > CNT_MAX ? CNT_MAX : cnt_model)) begin n_fail++; $display("FAIL cnt_sat[%0d] got %0d want %0d", i, minneg_cnt_o, cnt_model > CNT_MAX ? CNT_MAX : cnt_model); end
        end
        valid_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        ready_i = 1'b0; valid_i = 1'b1; data_i = 12'h800;
        tick();
        data_i = 12'h123;
        tick();
        n_cmp++; if (ready_o !== 1'b0 || valid_o !== 1'b1) begin n_fail++; $display("FAIL mid_full got ready %b valid %b want 0 1", ready_o, valid_o); end
        rst_i = 1'b1; valid_i = 1'b0;
        tick();
        rst_i = 1'b0;
        n_cmp++; if ({valid_o, ready_o} !== 2'b01) begin n_fail++; $display("FAIL mid_rst got valid %b ready %b want 0 1", valid_o, ready_o); end
        n_cmp++; if (minneg_cnt_o !== '0) begin n_fail++; $display("FAIL mid_rst_cnt got %0d want 0", minneg_cnt_o); end
        exp_q.delete(); obs_q.delete();
        ready_i = 1'b1; valid_i = 1'b1; data_i = 12'hFF0;
        tick();
        valid_i = 1'b0;
        n_cmp++; if (valid_o !== 1'b1 || {mag_o, sign_o, zero_o, sat_o} !== model(12'hFF0)) begin n_fail++; $display("FAIL mid_next got %b/%h want 1/%h", valid_o, {mag_o, sign_o, zero_o, sat_o}, model(12'hFF0)); end
        tick();
        n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_alone got valid %b want 0", valid_o); end
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
        cur_out = '0; cur_vld = 1'b0; cur_stall = 1'b0; cur_rdy = 1'b0; in_fire = 1'b0;
        test_reset();
        test_convert();
        test_minneg();
        test_backpressure();
        test_full_rate();
        test_random_backpressure();
        test_counter_sat();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sign_magnitude_split.md
Name: sign_magnitude_split

Overview:
- Streaming converter from 2's-complement words to sign/magnitude form. It is the decode direction of the sign-inversion path.
- Downstream arithmetic works on the unsigned magnitude and carries the sign bit separately. A later sign inverter, with sign_o driving its select, restores the signed value.
- Sits between a signed sample source and unsigned interpolation/scaling stages.
- Registered valid/ready handshake on both sides, with a 2-entry skid buffer.

Parameters:
- DATA_WIDTH, 12: width of the input word and of the magnitude output.
- CNT_WIDTH, 8: width of the saturating counter of most-negative inputs.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- data_i  input  DATA_WIDTH  2's-complement sample.
- valid_i  input  1  data_i is valid.
- ready_o  output  1  block can accept data_i this cycle.
- mag_o  output  DATA_WIDTH  unsigned magnitude |data_i|.
- sign_o  output  1  1 = input was negative.
- zero_o  output  1  1 = input was zero.
- sat_o  output  1  1 = word was the most-negative input, -2^(DATA_WIDTH-1).
- valid_o  output  1  mag_o/sign_o/zero_o/sat_o are valid.
- ready_i  input  1  downstream accepts the output this cycle.
- minneg_cnt_o  output  CNT_WIDTH  count of accepted most-negative inputs.

Behaviour:
- Reset, rst_i high at a clock edge:
  - valid_o=0, mag_o=0, sign_o=0, zero_o=0, sat_o=0.
  - skid buffer empty, ready_o=1, minneg_cnt_o=0.
  - Reset overrides any concurrent handshake. In-flight words are discarded, not delivered.
- Transfers:
  - Input transfer occurs when valid_i && ready_o.
  - Output transfer occurs when valid_o && ready_i.
- Conversion (combinational, ahead of the registers):
  - sign = data_i[DATA_WIDTH-1].
  - mag = sign ? (~data_i + 1) : data_i, evaluated at DATA_WIDTH bits, treated as unsigned.
  - zero = (data_i == 0).
  - sat = (data_i == {1'b1, {DATA_WIDTH-1{1'b0}}}).
- Storage: output register (OUT) and skid register (SKID), each with its own valid flag. There is no state machine beyond these two flags, giving states EMPTY, ONE (OUT only) and FULL (OUT+SKID).
  - ready_o = !skid_valid. It is a registered flag, with no combinational path from ready_i.
  - Input transfer, OUT empty or output transfer this cycle, SKID empty: the converted word loads OUT.
  - Input transfer, OUT full and held (ready_i=0): the converted word loads SKID. ready_o goes low the next cycle.
  - Output transfer while SKID valid: SKID moves to OUT and SKID clears. Any input transfer that cycle is impossible, since ready_o=0.
  - Output transfer, no new input, SKID empty: valid_o goes to 0 the next cycle.
- Latency and throughput:
  - Latency is 1 cycle from input transfer to valid_o, when OUT is free.
  - Full throughput is 1 word/cycle with ready_i held high.
- Ordering is strictly FIFO. No word is dropped or duplicated under any ready_i pattern.
- While valid_o=1 && ready_i=0, outputs hold stable.
- minneg_cnt_o:
  - Increments by 1 on each input transfer with sat=1.
  - Saturates at 2^CNT_WIDTH-1 and does not wrap.
  - Cleared only by rst_i.
- Inputs while valid_i=0 are ignored. X on data_i with valid_i=0 must not propagate.

Optional Feature:
- Macro: SIGN_MAGNITUDE_SPLIT_CLAMP_EN.
- Defined:
  - The most-negative input gives mag_o = 2^(DATA_WIDTH-1)-1 (clamped), with sign_o=1 and sat_o=1.
  - mag_o MSB is therefore always 0, so the magnitude fits a signed DATA_WIDTH field.
- Undefined:
  - The most-negative input gives the exact mag_o = 2^(DATA_WIDTH-1), unsigned, MSB=1, with sat_o=1.
- The counter and sat_o behave identically in both builds.

Test Plan:
- Conversion, DATA_WIDTH=12, ready_i=1: data_i=0xFFB (-5) -> next cycle mag_o=5, sign_o=1, zero_o=0.
  - data_i=0x7FF -> mag_o=2047, sign_o=0.
  - data_i=0x000 -> mag_o=0, sign_o=0, zero_o=1.
- Most-negative word: data_i=0x800 -> sign_o=1, sat_o=1, minneg_cnt_o=1.
  - mag_o=0x800 without the macro; mag_o=0x7FF with SIGN_MAGNITUDE_SPLIT_CLAMP_EN.
- Backpressure: stream 1,2,3,4,5 with valid_i=1, ready_i=0 for cycles 2-4.
  - ready_o falls after 2 words are held.
  - Output sequence mag 1,2,3,4,5 with no gaps once ready_i=1, no loss, no duplication.
- Full-rate stream of 100 random words with ready_i=1: one output per cycle, latency 1, values match the reference model.
- Counter saturation, CNT_WIDTH=2: feed 0x800 five times -> minneg_cnt_o = 1,2,3,3,3.
- Reset mid-operation: FULL state with ready_i=0, then rst_i=1 for one cycle.
  - Next cycle valid_o=0, ready_o=1, minneg_cnt_o=0.
  - The next input appears alone after 1 cycle.
